// File: rtl/aes_pkg.sv
// Shared AES-128 constants, S-box tables, GF(2^8) helpers and the decryptor FSM state type.
package aes_pkg;

  localparam int AES_NR = 10;

  localparam logic [7:0] RCON [1:AES_NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [2:0] {
    S_IDLE, S_KEYEXP, S_ADDKEY, S_ROUND, S_DONE
  } state_t;

  // Indices outside 1..10 occur only while the constant is unused, so they map to zero.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return (i >= 4'd1 && i <= 4'd10) ? RCON[i] : 8'h00;
  endfunction

  // Each table row holds the 16 entries sharing one upper nibble, entry 0 leftmost.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [127:0] row;
    case (a[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[127 - 8 * int'(a[3:0]) -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [127:0] row;
    case (a[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      4'hf: row = 128'h172b047eba77d626e169146355210c7d;
    endcase
    return row[127 - 8 * int'(a[3:0]) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] s,
  input  logic [127:0] rk_prev,
  input  logic         last,
  output logic [127:0] next_s
);

  logic [127:0] ark;
  logic [127:0] mixed;
  logic [7:0]   a0, a1, a2, a3;

  // NOTE: every variable gets a default before the loops so no path leaves it unassigned (no latch).
  always_comb begin
    ark   = '0;
    mixed = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    // Byte (row r, col c) sits at index 4c+r; row r rotates right by r positions.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127 - 8 * (4 * c + r) -: 8] = inv_sbox(s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
      end
    end
    ark = ark ^ rk_prev;
    for (int c = 0; c < 4; c++) begin
      a0 = ark[127 - 32 * c -: 8];
      a1 = ark[119 - 32 * c -: 8];
      a2 = ark[111 - 32 * c -: 8];
      a3 = ark[103 - 32 * c -: 8];
      mixed[127 - 32 * c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
      };
    end
    next_s = last ? ark : mixed;
  end

endmodule

// File: rtl/aes_128_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key forward to round 10, then runs ten
// inverse rounds one per clock while walking the key schedule backwards.
module aes_128_decrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  state_t       state, next_state;
  logic [127:0] s, rk, rk_prev, next_s;
  logic [3:0]   cnt;

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one schedule step: recover the last three words first, then w0 from the old w3.
  function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  assign rk_prev  = inv_key(rk, rcon(cnt + 4'd1));
  assign in_ready = (state == S_IDLE);
  assign busy     = (state == S_KEYEXP) || (state == S_ADDKEY) || (state == S_ROUND);

  aes_inv_round u_inv_round (
    .s       (s),
    .rk_prev (rk_prev),
    .last    (cnt == 4'd0),
    .next_s  (next_s)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (in_valid) next_state = S_KEYEXP;
      S_KEYEXP: if (cnt == 4'd10) next_state = S_ADDKEY;
      S_ADDKEY: next_state = S_ROUND;
      S_ROUND:  if (cnt == 4'd0) next_state = S_DONE;
      S_DONE:   if (out_valid && out_ready) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      rk        <= '0;
      cnt       <= '0;
      plaintext <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          s   <= ciphertext;
          rk  <= key;
          cnt <= 4'd1;
        end
        S_KEYEXP: begin
          rk  <= next_key(rk, rcon(cnt));
          cnt <= cnt + 4'd1;
        end
        S_ADDKEY: begin
          s   <= s ^ rk;
          cnt <= 4'd9;
        end
        S_ROUND: begin
          rk <= rk_prev;
          s  <= next_s;
          if (cnt == 4'd0) begin
            plaintext <= next_s;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
